ff_div_k4_q2: RTL and testbench

//  Sequential GF(2^4) divider: quot = dividend * divisor^-1, with divisor^-1 = divisor^14.

---
 rtl/gf16_pkg.sv | 21 ++
 rtl/gf16_mul.sv | 28 ++
 rtl/ff_div_k4_q2.sv | 148 ++++++++++++++
 tb/tb_ff_div_k4_q2.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gf16_pkg.sv
// Shared GF(2^4) definitions for the field divider and its multiplier instances.
// Elements are 4-bit polynomials reduced by x^4 = POLY.
package gf16_pkg;

    localparam logic [3:0] GF16_POLY = 4'b0011;

    typedef logic [3:0] gf16_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Multiply by x, folding the x^4 term back through the field polynomial.
    function automatic gf16_t gf16_xtime(input gf16_t v, input gf16_t poly);
        return {v[2:0], 1'b0} ^ (v[3] ? poly : 4'b0000);
    endfunction

endpackage

// File: rtl/gf16_mul.sv
// Combinational GF(2^4) multiplier: p = a * b mod (x^4 + POLY).
// Shift-and-add over the bits of b; squaring is this block with a == b.
module gf16_mul
    import gf16_pkg::*;
#(
    parameter logic [3:0] POLY = GF16_POLY
) (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] p
);

    gf16_t w_sum;
    gf16_t w_shift;

    always_comb begin
        w_sum   = '0;
        w_shift = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                w_sum = w_sum ^ w_shift;
            end
            w_shift = gf16_xtime(w_shift, POLY);
        end
        p = w_sum;
    end

endmodule

// File: rtl/ff_div_k4_q2.sv
// Sequential GF(2^4) divider: quot = dividend * divisor^14 (= dividend / divisor).
// One job in flight, valid/ready on both sides, result four edges after acceptance.
//
//  state | meaning
//  IDLE  | in_ready high, waiting for operands
//  ITER  | three square-and-multiply steps building acc = b^14
//  FINAL | form a * acc, flag b == 0, raise out_valid
//  DONE  | hold result until out_ready
module ff_div_k4_q2
    import gf16_pkg::*;
#(
    parameter logic [3:0] POLY = GF16_POLY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] quot,
    output logic       div_by_zero
);

    state_t     r_state;
    gf16_t      r_a;
    gf16_t      r_b;
    gf16_t      r_acc;
    gf16_t      r_pw;
    logic [1:0] r_cnt;
    gf16_t      r_quot;
    logic       r_dbz;
    logic       r_out_valid;

    state_t     w_state_nx;
    gf16_t      w_a_nx;
    gf16_t      w_b_nx;
    gf16_t      w_acc_nx;
    gf16_t      w_pw_nx;
    logic [1:0] w_cnt_nx;
    gf16_t      w_quot_nx;
    logic       w_dbz_nx;
    logic       w_out_valid_nx;

    gf16_t      w_pw_sq;
    gf16_t      w_acc_mul;
    gf16_t      w_quot_mul;

    gf16_mul #(.POLY(POLY)) u_mul_sq (
        .a (r_pw),
        .b (r_pw),
        .p (w_pw_sq)
    );

    gf16_mul #(.POLY(POLY)) u_mul_acc (
        .a (r_acc),
        .b (w_pw_sq),
        .p (w_acc_mul)
    );

    gf16_mul #(.POLY(POLY)) u_mul_quot (
        .a (r_a),
        .b (r_acc),
        .p (w_quot_mul)
    );

    always_comb begin
        w_state_nx     = r_state;
        w_a_nx         = r_a;
        w_b_nx         = r_b;
        w_acc_nx       = r_acc;
        w_pw_nx        = r_pw;
        w_cnt_nx       = r_cnt;
        w_quot_nx      = r_quot;
        w_dbz_nx       = r_dbz;
        w_out_valid_nx = r_out_valid;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_a_nx     = dividend;
                    w_b_nx     = divisor;
                    w_acc_nx   = 4'd1;
                    w_pw_nx    = divisor;
                    w_cnt_nx   = 2'd0;
                    w_state_nx = ITER;
                end
            end
            ITER: begin
                w_pw_nx  = w_pw_sq;
                w_acc_nx = w_acc_mul;
                // cnt wraps to 0 on the last step so it never reaches 3.
                if (r_cnt == 2'd2) begin
                    w_cnt_nx   = 2'd0;
                    w_state_nx = FINAL;
                end else begin
                    w_cnt_nx = r_cnt + 2'd1;
                end
            end
            FINAL: begin
                w_quot_nx      = w_quot_mul;
                w_dbz_nx       = (r_b == 4'd0);
                w_out_valid_nx = 1'b1;
                w_state_nx     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_out_valid_nx = 1'b0;
                    w_state_nx     = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_pw        <= '0;
            r_cnt       <= '0;
            r_quot      <= '0;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_a         <= w_a_nx;
            r_b         <= w_b_nx;
            r_acc       <= w_acc_nx;
            r_pw        <= w_pw_nx;
            r_cnt       <= w_cnt_nx;
            r_quot      <= w_quot_nx;
            r_dbz       <= w_dbz_nx;
            r_out_valid <= w_out_valid_nx;
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = r_out_valid;
    assign quot        = r_quot;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_ff_div_k4_q2.sv
// Directed and exhaustive checks of the GF(2^4) divider against a log/antilog model.
module tb_ff_div_k4_q2;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] quot;
    logic       div_by_zero;

    int n_cmp;
    int n_err;

    int exp_t [15];
    int log_t [16];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic       dbz;
    } vec_t;

    vec_t vecs [7];

    ff_div_k4_q2 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quot        (quot),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [3:0] model_div(input int a, input int b);
        if (a == 0 || b == 0) return 4'd0;
        return 4'(exp_t[(log_t[a] - log_t[b] + 15) % 15]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job; checks latency, result and the output handshake.
    task automatic do_job(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] exp_q, input logic exp_dbz, input int stall);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) chk({name, "_in_ready_timeout"}, 0, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, n, 4);
        chk({name, "_quot"}, int'(quot), int'(exp_q));
        chk({name, "_dbz"}, int'(div_by_zero), int'(exp_dbz));
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_ov_drop"}, int'(out_valid), 0);
    endtask

    initial begin
        int e;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 4'd0;
        divisor   = 4'd0;

        e = 1;
        log_t[0] = 0;
        for (int i = 0; i < 15; i++) begin
            exp_t[i] = e;
            log_t[e] = i;
            e = e << 1;
            if (e >= 16) e = e ^ 19;
        end

        vecs[0] = '{4'd12, 4'd3,  4'd4,  1'b0};
        vecs[1] = '{4'd4,  4'd2,  4'd2,  1'b0};
        vecs[2] = '{4'd14, 4'd8,  4'd5,  1'b0};
        vecs[3] = '{4'd10, 4'd15, 4'd15, 1'b0};
        vecs[4] = '{4'd1,  4'd2,  4'd9,  1'b0};
        vecs[5] = '{4'd7,  4'd0,  4'd0,  1'b1};
        vecs[6] = '{4'd1,  4'd1,  4'd1,  1'b0};

        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_quot", int'(quot), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            do_job($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dbz, i % 3);
            chk($sformatf("vec%0d_in_ready_after", i), int'(in_ready), 1);
        end

        // Backpressure: result held, new operands ignored while DONE.
        dividend = 4'd12;
        divisor  = 4'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_out_valid_start", int'(out_valid), 1);
        dividend = 4'd9;
        divisor  = 4'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("bp%0d_quot", i), int'(quot), 4);
            chk($sformatf("bp%0d_out_valid", i), int'(out_valid), 1);
            chk($sformatf("bp%0d_in_ready", i), int'(in_ready), 0);
            chk($sformatf("bp%0d_dbz", i), int'(div_by_zero), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_out_valid", int'(out_valid), 0);
        chk("bp_release_in_ready", int'(in_ready), 1);
        chk("bp_release_quot", int'(quot), 4);

        // out_ready while idle is harmless.
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        chk("idle_out_ready_ov", int'(out_valid), 0);
        do_job("after_bp", 4'd4, 4'd2, 4'd2, 1'b0, 1);

        // Async reset in the middle of ITER.
        dividend = 4'd12;
        divisor  = 4'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_quot", int'(quot), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("midrst_still_idle", int'(out_valid), 0);
        do_job("post_rst", 4'd12, 4'd3, 4'd4, 1'b0, 0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_job($sformatf("ex_a%0d_b%0d", a, b), 4'(a), 4'(b),
                       model_div(a, b), (b == 0), int'($urandom_range(0, 3)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
